mem_master: RTL and testbench

Bus initiator for the CPU-to-memory/IO protocol (`mem_cmd`/`mem_addr`/`write_data`/`read_data`). A datapath client hands it one load or store at a time, and it sequences the bus cycles. For a read, it holds `MREAD` across the synchronous-RAM latency, captures `read_data`, and returns it with a one-cycle `done` pulse. It sits between the datapath/controller and the top-level RAM and IO decode, in place of ad-hoc bus driving in the CPU FSM.

---
 rtl/mem_bus_pkg.sv | 21 ++
 rtl/mem_addr_decode.sv | 18 +
 rtl/mem_master.sv | 128 ++++++++++++
 tb/tb_mem_master.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU memory/IO bus: command
// encodings, decoded IO addresses, widths and master states.
package mem_bus_pkg;
  localparam int AW = 9;
  localparam int DW = 16;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic [AW-1:0] SWADDR  = 9'h140;
  localparam logic [AW-1:0] LEDADDR = 9'h100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_DONE,
    S_ERR
  } state_t;
endpackage

// File: rtl/mem_addr_decode.sv
// Legality check of a bus address and direction.
// Ports: addr, write in; legal out (RAM, switch read, LED write).
module mem_addr_decode
  import mem_bus_pkg::*;
(
  input  logic [AW-1:0] addr,
  input  logic          write,
  output logic          legal
);
  logic w_ram;
  logic w_sw;
  logic w_led;

  assign w_ram = ~addr[AW-1];
  assign w_sw  = ~write & (addr == SWADDR);
  assign w_led = write & (addr == LEDADDR);
  assign legal = w_ram | w_sw | w_led;
endmodule

// File: rtl/mem_master.sv
// Bus initiator: sequences one load/store on the memory bus.
// Ports: clk, reset (sync, active-high); req/req_write/
// req_addr/req_wdata in; busy/done/rdata/err out; bus side
// mem_cmd/mem_addr/write_data out, read_data in.
// Option MEM_MASTER_DECERR_EN: decode errors via err.
module mem_master
  import mem_bus_pkg::*;
#(
  parameter int RD_WAIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] write_data,
  input  logic [DW-1:0] read_data
);
  localparam int CW = (RD_WAIT < 1) ? 1
                    : $clog2(RD_WAIT + 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_cmd;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          w_legal;

`ifdef MEM_MASTER_DECERR_EN
  mem_addr_decode u_dec (
    .addr  (req_addr),
    .write (req_write),
    .legal (w_legal)
  );
`else
  assign w_legal = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cmd   <= MNONE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          r_err <= 1'b0;
          if (req) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_busy  <= 1'b1;
            if (!w_legal) begin
              r_state <= S_ERR;
              r_cmd   <= MNONE;
            end else if (req_write) begin
              r_state <= S_WR;
              r_cmd   <= MWRITE;
            end else begin
              r_state <= S_RD;
              r_cmd   <= MREAD;
              r_cnt   <= CW'(RD_WAIT);
            end
          end else begin
            r_state <= S_IDLE;
            r_cmd   <= MNONE;
            r_busy  <= 1'b0;
          end
        end
        S_WR: begin
          r_state <= S_DONE;
          r_cmd   <= MNONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        S_RD: begin
          // read_data is valid at the edge the count hits 0
          if (r_cnt == '0) begin
            r_rdata <= read_data;
            r_state <= S_DONE;
            r_cmd   <= MNONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_ERR: begin
          r_state <= S_DONE;
          r_cmd   <= MNONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_err   <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_cmd   <= MNONE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign rdata      = r_rdata;
  assign err        = r_err;
  assign mem_cmd    = r_cmd;
  assign mem_addr   = r_addr;
  assign write_data = r_wdata;
endmodule

// File: tb/tb_mem_master.sv
// Self-checking bench for mem_master (RD_WAIT=1 and 3).
// Honours MEM_MASTER_DECERR_EN for decode-error vectors.
module tb_mem_master;
  import mem_bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req, req3, req_write;
  logic [8:0]  req_addr;
  logic [15:0] req_wdata;

  logic        busy, done, err;
  logic [15:0] rdata;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data, read_data;

  logic        busy3, done3, err3;
  logic [15:0] rdata3;
  logic [1:0]  mem_cmd3;
  logic [8:0]  mem_addr3;
  logic [15:0] write_data3, read_data3;

  mem_master #(.RD_WAIT(1)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy), .done(done),
    .rdata(rdata), .err(err), .mem_cmd(mem_cmd),
    .mem_addr(mem_addr), .write_data(write_data),
    .read_data(read_data)
  );

  mem_master #(.RD_WAIT(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy3), .done(done3),
    .rdata(rdata3), .err(err3), .mem_cmd(mem_cmd3),
    .mem_addr(mem_addr3), .write_data(write_data3),
    .read_data(read_data3)
  );

  // Responders: sync-read RAM plus switch register
  logic [15:0] ram [512];
  logic [15:0] sw_val = 16'h00A5;
  always @(posedge clk) begin
    if (mem_cmd == MWRITE && !mem_addr[8])
      ram[mem_addr] <= write_data;
    if (mem_cmd == MREAD)
      read_data <= (mem_addr == SWADDR) ? sw_val
                                        : ram[mem_addr];
    if (mem_cmd3 == MREAD)
      read_data3 <= {7'h0, mem_addr3} ^ 16'hBEEF;
  end

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  typedef struct packed {
    logic [15:0] rd;
    logic        er;
  } sb_t;
  sb_t sbq[$];

  int n_wr = 0, n_rd = 0, n_done = 0;
  logic [8:0]  last_wa;
  logic [15:0] last_wd;

  // Bus monitor and scoreboard consumer
  always @(negedge clk) begin
    if (mem_cmd == MWRITE) begin
      n_wr++;
      last_wa = mem_addr;
      last_wd = write_data;
    end
    if (mem_cmd == MREAD) n_rd++;
    if (done) begin
      n_done++;
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        sb_t e;
        e = sbq.pop_front();
        chk("done_rdata", 32'(rdata), 32'(e.rd));
        chk("done_err", 32'(err), 32'(e.er));
        chk("done_busy", 32'(busy), 32'(0));
        chk("done_cmd", 32'(mem_cmd), 32'(MNONE));
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_err;
    int          lat;
    int          nwr;
    int          nrd;
  } vec_t;
  vec_t vecs[11];

  function automatic vec_t mk(logic w, logic [8:0] a,
      logic [15:0] d, logic [15:0] r, logic e, int l,
      int nw, int nr);
    vec_t v;
    v.wr = w; v.addr = a; v.wdata = d; v.exp_rd = r;
    v.exp_err = e; v.lat = l; v.nwr = nw; v.nrd = nr;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int lat, wr0, rd0;
    @(negedge clk);
    chk($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'(0));
    req = 1'b1;
    req_write = v.wr;
    req_addr = v.addr;
    req_wdata = v.wdata;
    sbq.push_back({v.exp_rd, v.exp_err});
    wr0 = n_wr;
    rd0 = n_rd;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 20);
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d_nwrite", idx), 32'(n_wr - wr0),
        32'(v.nwr));
    chk($sformatf("v%0d_nread", idx), 32'(n_rd - rd0),
        32'(v.nrd));
    if (v.nwr > 0) begin
      chk($sformatf("v%0d_waddr", idx), 32'(last_wa),
          32'(v.addr));
      chk($sformatf("v%0d_wdata", idx), 32'(last_wd),
          32'(v.wdata));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] cmd_tr [6];
    logic       dn_tr [6];
    int         d0;

    reset = 1'b1;
    req = 1'b0;
    req3 = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;

    vecs[0]  = mk(1, 9'h005, 16'h1234, 16'h0000, 0, 2, 1, 0);
    vecs[1]  = mk(0, 9'h005, 16'h0000, 16'h1234, 0, 3, 0, 2);
    vecs[2]  = mk(1, 9'h0AA, 16'hCAFE, 16'h1234, 0, 2, 1, 0);
    vecs[3]  = mk(0, 9'h140, 16'h0000, 16'h00A5, 0, 3, 0, 2);
    vecs[4]  = mk(1, 9'h100, 16'h00FF, 16'h00A5, 0, 2, 1, 0);
    vecs[5]  = mk(0, 9'h0AA, 16'h0000, 16'hCAFE, 0, 3, 0, 2);
`ifdef MEM_MASTER_DECERR_EN
    vecs[6]  = mk(1, 9'h140, 16'h7777, 16'hCAFE, 1, 2, 0, 0);
`else
    vecs[6]  = mk(1, 9'h140, 16'h7777, 16'hCAFE, 0, 2, 1, 0);
`endif
    vecs[7]  = mk(1, 9'h00A, 16'h0A0A, 16'hCAFE, 0, 2, 1, 0);
    vecs[8]  = mk(1, 9'h00B, 16'h0B0B, 16'hCAFE, 0, 2, 1, 0);
    vecs[9]  = mk(1, 9'h000, 16'hFFFF, 16'hCAFE, 0, 2, 1, 0);
    vecs[10] = mk(0, 9'h000, 16'h0000, 16'hFFFF, 0, 3, 0, 2);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd", 32'(mem_cmd), 32'(MNONE));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    chk("rst_addr", 32'(mem_addr), 32'(0));
    chk("rst_wdata", 32'(write_data), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst3_cmd", 32'(mem_cmd3), 32'(MNONE));
    chk("rst3_busy", 32'(busy3), 32'(0));
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Back-to-back loads with req held high
    @(negedge clk);
    req = 1'b1;
    req_write = 1'b0;
    req_addr = 9'h00A;
    sbq.push_back({16'h0A0A, 1'b0});
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmd_tr[i] = mem_cmd;
      dn_tr[i] = done;
      if (i == 2) begin
        req_addr = 9'h00B;
        sbq.push_back({16'h0B0B, 1'b0});
      end
      if (i == 3) req = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("b2b_cmd%0d", i), 32'(cmd_tr[i]),
          32'((i == 2 || i == 5) ? MNONE : MREAD));
      chk($sformatf("b2b_done%0d", i), 32'(dn_tr[i]),
          32'((i == 2 || i == 5) ? 1 : 0));
    end

    // RD_WAIT=3 load with a request arriving while busy
    @(negedge clk);
    req3 = 1'b1;
    req_write = 1'b0;
    req_addr = 9'h033;
    @(posedge clk);
    #1;
    req_write = 1'b1;
    req_addr = 9'h044;
    req_wdata = 16'h4444;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk($sformatf("rw3_cmd%0d", i), 32'(mem_cmd3),
          32'((i <= 4) ? MREAD : MNONE));
      chk($sformatf("rw3_done%0d", i), 32'(done3),
          32'((i == 5) ? 1 : 0));
      if (i <= 4)
        chk($sformatf("rw3_addr%0d", i), 32'(mem_addr3),
            32'(9'h033));
      if (i == 5) begin
        chk("rw3_rdata", 32'(rdata3),
            32'(16'h0033 ^ 16'hBEEF));
        chk("rw3_err", 32'(err3), 32'(0));
      end
      if (i == 4) req3 = 1'b0;
    end

    // Reset in the first MREAD cycle, then req with reset
    @(negedge clk);
    req = 1'b1;
    req_write = 1'b0;
    req_addr = 9'h005;
    @(posedge clk);
    #1 req = 1'b0;
    d0 = n_done;
    @(negedge clk);
    chk("mrst_pre_cmd", 32'(mem_cmd), 32'(MREAD));
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_cmd", 32'(mem_cmd), 32'(MNONE));
    chk("mrst_busy", 32'(busy), 32'(0));
    chk("mrst_done", 32'(done), 32'(0));
    chk("mrst_rdata", 32'(rdata), 32'(0));
    chk("mrst_addr", 32'(mem_addr), 32'(0));
    chk("mrst_wdata", 32'(write_data), 32'(0));
    chk("mrst_err", 32'(err), 32'(0));
    req = 1'b1;
    req_addr = 9'h0AA;
    @(negedge clk);
    chk("rstreq_busy", 32'(busy), 32'(0));
    chk("rstreq_cmd", 32'(mem_cmd), 32'(MNONE));
    req = 1'b0;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("mrst_no_done", 32'(n_done - d0), 32'(0));

    run_vec(mk(0, 9'h0AA, 16'h0000, 16'hCAFE, 0, 3, 0, 2), 11);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
